// File: rtl/muldiv_pkg.sv
// Shared widths for the multiply/divide datapath primitives.
package muldiv_pkg;

    localparam int ADD_W = 32;              // adder operand/sum width
    localparam int REG_W = 65;              // holding register width
    localparam int CLA_W = 4;               // bits per carry-lookahead group
    localparam int N_GRP = ADD_W / CLA_W;   // number of cascaded groups

endpackage : muldiv_pkg

// File: rtl/adder32_reg65_if.sv
// Bundle of the adder and register signals for adder32_reg65.
// Optional feature macro: ADDER32_OVF_EN adds the signed-overflow signal ovf.
interface adder32_reg65_if;
    import muldiv_pkg::*;

    // register half
    logic             en;
    logic [REG_W-1:0] d;
    logic [REG_W-1:0] q;

    // adder half
    logic [ADD_W-1:0] a;
    logic [ADD_W-1:0] b;
    logic             cin;
    logic [ADD_W-1:0] sum;
    logic             cout;
`ifdef ADDER32_OVF_EN
    logic             ovf;

    modport master (output en, d, a, b, cin, input q, sum, cout, ovf);
    modport slave  (input en, d, a, b, cin, output q, sum, cout, ovf);
`else
    modport master (output en, d, a, b, cin, input q, sum, cout);
    modport slave  (input en, d, a, b, cin, output q, sum, cout);
`endif

endinterface : adder32_reg65_if

// File: rtl/adder32_reg65_cla4.sv
// 4-bit carry-lookahead group: sum, carry-out and group generate/propagate.
module cla4
    import muldiv_pkg::*;
(
    input  logic [CLA_W-1:0] i_a,
    input  logic [CLA_W-1:0] i_b,
    input  logic             i_cin,
    output logic [CLA_W-1:0] o_s,
    output logic             o_cout,
    output logic             o_g,
    output logic             o_p
);

    logic [CLA_W-1:0] w_g;   // per-bit generate
    logic [CLA_W-1:0] w_p;   // per-bit propagate
    logic [CLA_W:0]   w_c;   // carry into each bit, plus carry out

    assign w_g = i_a & i_b;
    assign w_p = i_a ^ i_b;

    // Every carry is flattened from i_cin so no carry ripples inside the group.
    assign w_c[0] = i_cin;
    assign w_c[1] = w_g[0] | (w_p[0] & i_cin);
    assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & i_cin);
    assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                  | (w_p[2] & w_p[1] & w_p[0] & i_cin);

    assign o_g = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
               | (w_p[3] & w_p[2] & w_p[1] & w_g[0]);
    assign o_p = &w_p;

    assign w_c[4] = o_g | (o_p & i_cin);

    assign o_s    = w_p ^ w_c[CLA_W-1:0];
    assign o_cout = w_c[CLA_W];

endmodule : cla4

// File: rtl/adder32_reg65.sv
// 32-bit carry-lookahead adder (8 groups, ripple between groups) and an
// independent 65-bit enabled register with synchronous clear.
// Optional feature macro: ADDER32_OVF_EN exposes signed overflow on ovf.
module adder32_reg65
    import muldiv_pkg::*;
(
    input  logic            clock,
    input  logic            reset,
    adder32_reg65_if.slave  io_bus
);

    logic [N_GRP:0]   w_c;     // carry into each group; top bit is cout
    logic [N_GRP-1:0] w_g;     // group generate
    logic [N_GRP-1:0] w_p;     // group propagate
    logic [ADD_W-1:0] w_sum;
    logic [REG_W-1:0] r_q;

    assign w_c[0] = io_bus.cin;

    for (genvar gi = 0; gi < N_GRP; gi++) begin : g_cla
        cla4 u_cla4 (
            .i_a    (io_bus.a[gi*CLA_W +: CLA_W]),
            .i_b    (io_bus.b[gi*CLA_W +: CLA_W]),
            .i_cin  (w_c[gi]),
            .o_s    (w_sum[gi*CLA_W +: CLA_W]),
            .o_cout (w_c[gi+1]),
            .o_g    (w_g[gi]),
            .o_p    (w_p[gi])
        );
    end

    // Group G/P are kept for a future second lookahead level; the simple
    // inter-group ripple does not need them.
    logic w_unused_gp;
    assign w_unused_gp = ^{w_g, w_p};

    assign io_bus.sum  = w_sum;
    assign io_bus.cout = w_c[N_GRP];

`ifdef ADDER32_OVF_EN
    // The carry into bit 31 is a[31]^b[31]^sum[31]; overflow is that XOR cout.
    assign io_bus.ovf = io_bus.a[ADD_W-1] ^ io_bus.b[ADD_W-1]
                      ^ w_sum[ADD_W-1] ^ w_c[N_GRP];
`endif

    // Holding register: synchronous clear wins over load, otherwise hold.
    always_ff @(posedge clock) begin
        // NOTE: state is updated with <= so every reader of r_q sees the pre-edge
        // value; reset is sampled on the edge only and takes priority over en.
        if (reset) begin
            r_q <= '0;
        end else if (io_bus.en) begin
            r_q <= io_bus.d;
        end
    end

    assign io_bus.q = r_q;

endmodule : adder32_reg65

// File: tb/tb_adder32_reg65.sv
// Scoreboard bench for adder32_reg65: the driver pushes expected responses,
// a monitor pops and compares one entry per clock after the rising edge.
module tb_adder32_reg65;
    import muldiv_pkg::*;

    typedef struct {
        logic [31:0] sum;
        logic        cout;
        logic        ovf;
        logic [64:0] q;
        bit          chk_q;
        string       name;
    } exp_t;

    logic clock = 1'b0;
    logic reset;

    adder32_reg65_if bus ();

    adder32_reg65 dut (
        .clock  (clock),
        .reset  (reset),
        .io_bus (bus.slave)
    );

    always #5 clock = ~clock;

    exp_t        sb[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [64:0] m_q;
    bit          m_q_known = 1'b0;
    int          m_cnt = 0;

    task automatic check(input string name, input logic [64:0] act, input logic [64:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Unsigned reference: the 33-bit sum of the three operands.
    function automatic logic [32:0] ref_add(input logic [31:0] a, input logic [31:0] b,
                                            input logic cin);
        return {1'b0, a} + {1'b0, b} + {32'b0, cin};
    endfunction

`ifdef ADDER32_OVF_EN
    localparam longint S_MAX = 64'sd2147483647;
    localparam longint S_MIN = -64'sd2147483648;

    // Signed reference: true result falls outside the 32-bit two's-complement range.
    function automatic logic ref_ovf(input logic [31:0] a, input logic [31:0] b,
                                     input logic cin);
        longint s;
        s = longint'($signed(a)) + longint'($signed(b)) + longint'({63'b0, cin});
        return (s > S_MAX) || (s < S_MIN);
    endfunction
`endif

    task automatic push_exp(input logic [31:0] a, input logic [31:0] b, input logic cin,
                            input string name);
        exp_t        e;
        logic [32:0] r;
        r      = ref_add(a, b, cin);
        e.sum  = r[31:0];
        e.cout = r[32];
`ifdef ADDER32_OVF_EN
        e.ovf  = ref_ovf(a, b, cin);
`else
        e.ovf  = 1'b0;
`endif
        e.q     = m_q;
        e.chk_q = m_q_known;
        e.name  = name;
        sb.push_back(e);
    endtask

    // One cycle of free stimulus; the register model follows the clear/load/hold rule.
    task automatic apply(input logic [31:0] a, input logic [31:0] b, input logic cin,
                         input logic rst, input logic en, input logic [64:0] d,
                         input string name);
        @(negedge clock);
        reset   = rst;
        bus.en  = en;
        bus.d   = d;
        bus.a   = a;
        bus.b   = b;
        bus.cin = cin;
        if (rst) begin
            m_q       = '0;
            m_q_known = 1'b1;
        end else if (en) begin
            m_q = d;
        end
        push_exp(a, b, cin, name);
    endtask

    // One cycle of the closed increment loop; expected count is 0,1,..,32 then holds.
    task automatic loop_step(input logic rst, input string name);
        logic [31:0] b_v;
        @(negedge clock);
        b_v     = rst ? 32'h0 : bus.q[31:0];
        reset   = rst;
        bus.a   = 32'h1;
        bus.cin = 1'b0;
        bus.b   = b_v;
        bus.en  = ~bus.q[5];
        #1;
        bus.d   = {33'b0, bus.sum};
        if (rst) begin
            m_cnt = 0;
        end else if (m_cnt < 32) begin
            m_cnt++;
        end
        m_q       = 65'(m_cnt);
        m_q_known = 1'b1;
        push_exp(32'h1, b_v, 1'b0, name);
    endtask

    // Monitor: compare DUT outputs against the oldest pending expectation.
    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clock);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check({e.name, ".sum"},  65'(bus.sum),  65'(e.sum));
                check({e.name, ".cout"}, 65'(bus.cout), 65'(e.cout));
`ifdef ADDER32_OVF_EN
                check({e.name, ".ovf"},  65'(bus.ovf),  65'(e.ovf));
`endif
                if (e.chk_q) begin
                    check({e.name, ".q"}, bus.q, e.q);
                end
            end
        end
    end

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, %0d entries pending", sb.size());
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        reset   = 1'b0;
        bus.en  = 1'b0;
        bus.d   = '0;
        bus.a   = '0;
        bus.b   = '0;
        bus.cin = 1'b0;

        // Directed adder corners paired with register clear / load / hold.
        apply(32'h0000_0001, 32'h0000_0000, 1'b0, 1'b1, 1'b1, {65{1'b1}},               "rst_pri");
        apply(32'h0000_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1'b1, 65'h1_2345_6789_ABCD_EF01, "load");
        apply(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 1'b0, 65'h0_DEAD_BEEF_0BAD_F00D, "hold_wrap");
        apply(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1'b0, 65'h1_5555_AAAA_5555_AAAA, "hold_ovf");
        apply(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b1, 65'h1_FFFF_FFFF_FFFF_FFFF, "load_max");
        apply(32'h8000_0000, 32'h8000_0000, 1'b0, 1'b1, 1'b0, 65'h0_1234_5678_9ABC_DEF0, "rst_no_en");

        // Increment loop: counts up to 32 and then stalls on q[5].
        loop_step(1'b1, "cnt_rst");
        for (int i = 0; i < 40; i++) loop_step(1'b0, "cnt");

        // Reset in the middle of a count, then resume from zero.
        loop_step(1'b1, "cnt_rst2");
        for (int i = 0; i < 17; i++) loop_step(1'b0, "cnt_to17");
        loop_step(1'b1, "cnt_mid_rst");
        for (int i = 0; i < 6; i++) loop_step(1'b0, "cnt_resume");

        // Random operands with random register traffic and occasional clears.
        for (int i = 0; i < 10000; i++) begin
            apply($urandom, $urandom, 1'($urandom),
                  ($urandom_range(0, 63) == 0), 1'($urandom),
                  {1'($urandom), $urandom, $urandom}, "rand");
        end

        repeat (3) @(posedge clock);
        #2;
        check("drain_queue", 65'(sb.size()), 65'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_adder32_reg65
